// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU widths, NOP opcode and fetch state encoding
// Purpose : common constants for the fetch stage and the control unit.
// Contents: CPU_ADDR_W, CPU_INSTR_W, CPU_OPC_W defaults, NOP_OPC, fetch_state_t.
package cpu_pkg;

  localparam int CPU_ADDR_W  = 8;
  localparam int CPU_INSTR_W = 16;
  localparam int CPU_OPC_W   = 8;

  localparam logic [7:0] NOP_OPC = 8'h00;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/ifetch_ir_if.sv
// rtl/ifetch_ir_if.sv - program memory read bus (req/ack handshake)
// Purpose : groups the program memory signals between fetch stage and memory.
// Signals : mem_addr, mem_rd (fetch -> memory); mem_rdata, mem_ack (memory -> fetch).
// Modports: master = fetch stage, slave = program memory.
interface ifetch_ir_if import cpu_pkg::*; #(
  parameter int ADDR_W  = CPU_ADDR_W,
  parameter int INSTR_W = CPU_INSTR_W
) ();

  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_rd;
  logic [INSTR_W-1:0] mem_rdata;
  logic               mem_ack;

  modport master (output mem_addr, output mem_rd, input mem_rdata, input mem_ack);
  modport slave  (input mem_addr, input mem_rd, output mem_rdata, output mem_ack);

endinterface

// File: rtl/ifetch_ir_pc_counter.sv
// rtl/ifetch_ir_pc_counter.sv - program counter with branch load and pending branch
// Purpose : PC register, increment with wrap, direct branch load while idle and
//           a pending-branch register that replaces pc+1 at the end of a fetch.
// Ports   : clk, rst (async active-low), idle (fetch FSM in IDLE), branch_en,
//           branch_addr, advance (fetch accepted), done (fetch ended), pc.
module pc_counter #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              idle,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic              advance,
  input  logic              done,
  output logic [ADDR_W-1:0] pc
);

  logic              pend_valid;
  logic [ADDR_W-1:0] pend_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc         <= RESET_PC;
      pend_valid <= 1'b0;
      pend_addr  <= '0;
    end else begin
      if (idle && branch_en) begin
        pc <= branch_addr;
      end else if (advance) begin
        // A branch arriving in the ack cycle is the newest one and wins.
        if (branch_en)       pc <= branch_addr;
        else if (pend_valid) pc <= pend_addr;
        else                 pc <= pc + ADDR_W'(1);
      end

      if (!idle && branch_en) begin
        pend_valid <= 1'b1;
        pend_addr  <= branch_addr;
      end
      // Ending a fetch (ack or abort) discards any pending target.
      if (done) pend_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ifetch_ir.sv
// rtl/ifetch_ir.sv - instruction fetch stage and instruction register
// Purpose : fetches one word at pc over a req/ack bus, latches it into the IR and
//           presents opcode/operand fields. Optional macro FETCH_TIMEOUT_EN adds
//           a REQ-cycle timeout that aborts with a NOP and sets sticky fetch_err.
// Ports   : clk, rst (async active-low), fetch_req, branch_en, branch_addr,
//           mem (ifetch_ir_if.master), opcode, operand, ir_valid, pc, busy, fetch_err.
module ifetch_ir import cpu_pkg::*; #(
  parameter int                ADDR_W   = CPU_ADDR_W,
  parameter int                INSTR_W  = CPU_INSTR_W,
  parameter int                OPC_W    = CPU_OPC_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
`ifdef FETCH_TIMEOUT_EN
  ,
  parameter int                TIMEOUT_CYC = 15
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_req,
  input  logic                     branch_en,
  input  logic [ADDR_W-1:0]        branch_addr,
  ifetch_ir_if.master              mem,
  output logic [OPC_W-1:0]         opcode,
  output logic [INSTR_W-OPC_W-1:0] operand,
  output logic                     ir_valid,
  output logic [ADDR_W-1:0]        pc,
  output logic                     busy,
  output logic                     fetch_err
);

  fetch_state_t       state, next_state;
  logic               start, accept, abort;
  logic [INSTR_W-1:0] ir;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_hit;

  // Fires in the last allowed REQ cycle, so mem_rd is high for TIMEOUT_CYC cycles.
  assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               tmo_cnt <= '0;
    else if (start)         tmo_cnt <= '0;
    else if (state == REQ)  tmo_cnt <= tmo_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       fetch_err <= 1'b0;
    else if (abort) fetch_err <= 1'b1;
  end
`else
  assign fetch_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    start      = 1'b0;
    accept     = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (fetch_req) begin
          start      = 1'b1;
          next_state = REQ;
        end
      end
      REQ: begin
        if (mem.mem_ack) begin
          accept     = 1'b1;
          next_state = IDLE;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (tmo_hit) begin
          abort      = 1'b1;
          next_state = IDLE;
        end
`endif
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir       <= '0;
      ir_valid <= 1'b0;
    end else if (start) begin
      ir_valid <= 1'b0;
    end else if (accept) begin
      ir       <= mem.mem_rdata;
      ir_valid <= 1'b1;
    end else if (abort) begin
      ir       <= {OPC_W'(NOP_OPC), {(INSTR_W-OPC_W){1'b0}}};
      ir_valid <= 1'b1;
    end
  end

  pc_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk         (clk),
    .rst         (rst),
    .idle        (state == IDLE),
    .branch_en   (branch_en),
    .branch_addr (branch_addr),
    .advance     (accept),
    .done        (accept | abort),
    .pc          (pc)
  );

  // The state flop itself is the registered read strobe.
  assign mem.mem_rd   = (state == REQ);
  assign busy         = (state == REQ);
  assign mem.mem_addr = pc;
  assign opcode       = ir[INSTR_W-1 -: OPC_W];
  assign operand      = ir[INSTR_W-OPC_W-1:0];

endmodule

// File: tb/tb_ifetch_ir.sv
// tb/tb_ifetch_ir.sv - scoreboard testbench for ifetch_ir
module tb_ifetch_ir;
  import cpu_pkg::*;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
    logic [7:0]  pc_after;
    int          cycles;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       fetch_req = 1'b0;
  logic       branch_en = 1'b0;
  logic [7:0] branch_addr = 8'h00;
  logic [7:0] opcode;
  logic [7:0] operand;
  logic       ir_valid;
  logic [7:0] pc;
  logic       busy;
  logic       fetch_err;

  ifetch_ir_if #(.ADDR_W(8), .INSTR_W(16)) mem ();

  ifetch_ir dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_req   (fetch_req),
    .branch_en   (branch_en),
    .branch_addr (branch_addr),
    .mem         (mem),
    .opcode      (opcode),
    .operand     (operand),
    .ir_valid    (ir_valid),
    .pc          (pc),
    .busy        (busy),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic [7:0] m_pc = 8'h00;
  bit   mon_en = 1'b1;
  bit   prev_v = 1'b0;
  int   rd_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: checks the bus during REQ and pops one expectation per IR capture.
  always @(negedge clk) begin
    if (mon_en && rst) begin
      if (mem.mem_rd) begin
        rd_cnt++;
        if (sb.size() == 0) chk("rd_unexpected", 1, 0);
        else begin
          chk("mem_addr", mem.mem_addr, sb[0].addr);
          chk("busy", busy, 1);
        end
      end
      if (ir_valid && !prev_v) begin
        if (sb.size() == 0) chk("valid_unexpected", 1, 0);
        else begin
          mon_e = sb.pop_front();
          chk("opcode", opcode, mon_e.data[15:8]);
          chk("operand", operand, mon_e.data[7:0]);
          chk("pc_after", pc, mon_e.pc_after);
          chk("rd_cycles", rd_cnt, mon_e.cycles);
        end
        rd_cnt = 0;
      end
    end else begin
      rd_cnt = 0;
    end
    prev_v = ir_valid;
  end

  // One fetch: the expected word, address and next PC are pushed before the DUT runs.
  task automatic do_fetch(input bit br0, input logic [7:0] ba0, input int waits,
                          input int mid, input logic [7:0] mid_addr, input bit rnd_br,
                          input logic [15:0] data);
    bit         bon[$];
    logic [7:0] bval[$];
    exp_t       e;
    logic [7:0] tgt = 8'h00;
    bit         have = 1'b0;
    if (br0) m_pc = ba0;
    e.addr = m_pc;
    for (int i = 0; i <= waits; i++) begin
      bit         b;
      logic [7:0] v;
      b = rnd_br ? ($urandom_range(0, 3) == 0) : (i == mid);
      v = rnd_br ? 8'($urandom) : mid_addr;
      bon.push_back(b);
      bval.push_back(v);
      if (b) begin
        have = 1'b1;
        tgt  = v;
      end
    end
    e.pc_after = have ? tgt : 8'((int'(m_pc) + 1) % 256);
    e.data     = data;
    e.cycles   = waits + 1;
    m_pc       = e.pc_after;
    sb.push_back(e);

    fetch_req   = 1'b1;
    branch_en   = br0;
    branch_addr = ba0;
    @(posedge clk); #1;
    for (int i = 0; i <= waits; i++) begin
      fetch_req     = 1'($urandom_range(0, 1));
      branch_en     = bon[i];
      branch_addr   = bval[i];
      mem.mem_ack   = (i == waits);
      mem.mem_rdata = (i == waits) ? data : 16'($urandom);
      @(posedge clk); #1;
    end
    fetch_req   = 1'b0;
    branch_en   = 1'b0;
    mem.mem_ack = 1'b0;
  endtask

  // Idle cycles with stray acks (ignored) and occasional direct branches.
  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      mem.mem_ack   = 1'($urandom_range(0, 1));
      mem.mem_rdata = 16'($urandom);
      branch_en     = ($urandom_range(0, 3) == 0);
      branch_addr   = 8'($urandom);
      if (branch_en) m_pc = branch_addr;
      @(posedge clk); #1;
    end
    mem.mem_ack = 1'b0;
    branch_en   = 1'b0;
    if (n > 0) chk("idle_pc", pc, m_pc);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p;
    mem.mem_ack   = 1'b0;
    mem.mem_rdata = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc, 8'h00);
    chk("rst_mem_addr", mem.mem_addr, 8'h00);
    chk("rst_mem_rd", mem.mem_rd, 0);
    chk("rst_ir_valid", ir_valid, 0);
    chk("rst_opcode", opcode, 8'h00);
    chk("rst_operand", operand, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_fetch_err", fetch_err, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    do_fetch(1'b0, 8'h5A, 0, -1, 8'h00, 1'b0, 16'hA13C);
    do_fetch(1'b0, 8'h00, 3, -1, 8'h00, 1'b0, 16'h0507);
    do_fetch(1'b1, 8'h40, 1, -1, 8'h00, 1'b0, 16'h1234);
    do_fetch(1'b0, 8'h00, 2, 1, 8'h80, 1'b0, 16'hBEEF);
    do_fetch(1'b1, 8'hFF, 0, -1, 8'h00, 1'b0, 16'hC001);
    idle_gap(1);

    for (int k = 0; k < 40; k++) begin
      idle_gap($urandom_range(0, 2));
      do_fetch($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 4),
               -1, 8'h00, 1'b1, 16'($urandom));
    end
    idle_gap(1);
    chk("sb_drained", sb.size(), 0);

    // Reset in the 2nd wait cycle of REQ, then a late ack around release.
    mon_en    = 1'b0;
    fetch_req = 1'b1;
    @(posedge clk); #1;
    fetch_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("arst_mem_rd", mem.mem_rd, 0);
    chk("arst_ir_valid", ir_valid, 0);
    chk("arst_pc", pc, 8'h00);
    chk("arst_busy", busy, 0);
    mem.mem_ack   = 1'b1;
    mem.mem_rdata = 16'hFFFF;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    mem.mem_ack = 1'b0;
    chk("late_ack_pc", pc, 8'h00);
    chk("late_ack_valid", ir_valid, 0);
    chk("late_ack_rd", mem.mem_rd, 0);
    m_pc   = 8'h00;
    mon_en = 1'b1;
    do_fetch(1'b0, 8'h00, 1, -1, 8'h00, 1'b0, 16'h7E11);
    idle_gap(1);

`ifdef FETCH_TIMEOUT_EN
    mon_en    = 1'b0;
    p         = 0;
    fetch_req = 1'b1;
    @(posedge clk); #1;
    fetch_req = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem.mem_rd) p++;
      else break;
    end
    chk("tmo_rd_cycles", p, 15);
    chk("tmo_opcode", opcode, 8'h00);
    chk("tmo_operand", operand, 8'h00);
    chk("tmo_valid", ir_valid, 1);
    chk("tmo_err", fetch_err, 1);
    chk("tmo_pc", pc, m_pc);
`else
    p = 0;
    chk("no_err", fetch_err + p, 0);
`endif

    chk("sb_final", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ifetch_ir.md
Name: ifetch_ir

Overview:
Instruction fetch stage and instruction register (IR) sitting directly upstream of the microprogrammed control unit.
- Holds the program counter and fetches one instruction word from program memory over a req/ack handshake.
- Latches the word into the IR and presents the opcode field to the control unit's 8-bit IR input.
- The control unit drives fetch_req and branch_en; the operand field goes to the datapath.

Parameters:
ADDR_W, 8, program address / PC width
INSTR_W, 16, instruction word width; opcode = [INSTR_W-1:INSTR_W-OPC_W], operand = [INSTR_W-OPC_W-1:0]
OPC_W, 8, opcode width (matches control unit IR input)
RESET_PC, 0, PC value after reset
TIMEOUT_CYC, 15, max REQ cycles before abort (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
fetch_req  in  1  start a fetch at current PC (level, sampled in IDLE only)
branch_en  in  1  load PC from branch_addr
branch_addr  in  ADDR_W  branch target
mem_addr  out  ADDR_W  program memory address
mem_rd  out  1  read request, held until mem_ack
mem_rdata  in  INSTR_W  read data, valid when mem_ack=1
mem_ack  in  1  read complete
opcode  out  OPC_W  IR opcode field, to control unit
operand  out  INSTR_W-OPC_W  IR operand field
ir_valid  out  1  IR holds a freshly fetched instruction
pc  out  ADDR_W  current PC
busy  out  1  fetch in progress (state == REQ)
fetch_err  out  1  sticky fetch timeout flag (tied 0 without the optional feature)

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, pc=RESET_PC.
  - opcode, operand, ir_valid, mem_rd, busy, fetch_err all 0; mem_addr=RESET_PC.
  - Asserting reset mid-fetch drops mem_rd immediately; any late mem_ack after reset is ignored.
- FSM states: IDLE, REQ. All outputs are registered; mem_addr always equals pc.
- IDLE:
  - fetch_req=1: next state REQ and ir_valid<=0.
  - branch_en=1: pc<=branch_addr.
  - Both in the same cycle: the PC loads branch_addr and the fetch proceeds from branch_addr.
- REQ:
  - mem_rd=1 and busy=1.
  - On the first cycle with mem_ack=1: IR<=mem_rdata, ir_valid<=1, next state IDLE, mem_rd<=0.
  - PC update on ack: pc<=pc+1, wrapping modulo 2^ADDR_W (0xFF -> 0x00).
- fetch_req while in REQ is ignored; it is not queued.
- branch_en while in REQ: branch_addr is captured into a pending register.
  - On ack, pc<=pending target instead of pc+1.
  - The last branch_en before ack wins.
- mem_ack in IDLE is ignored.
- Latency: fetch_req sampled at edge N; mem_rd high after edge N; if mem_ack=1 before edge N+1, ir_valid=1 after edge N+1. Minimum 2 edges from request to valid IR.
- Wait states: mem_rd, mem_addr and the IR stay stable until ack.
- ir_valid stays high until the next accepted fetch_req. IR contents hold until the next successful capture.

Optional Feature:
- Macro FETCH_TIMEOUT_EN.
- When defined:
  - A cycle counter runs in REQ.
  - If TIMEOUT_CYC REQ cycles pass without mem_ack: abort to IDLE, drop mem_rd, load IR with the NOP word (all zeros), ir_valid<=1, fetch_err<=1 (sticky until reset), PC unchanged.
  - The counter clears on entry to REQ.
- When undefined: REQ waits indefinitely, no counter exists, and fetch_err is constant 0.

Decomposition:
- Shared package cpu_pkg holds:
  - ADDR_W, INSTR_W and OPC_W defaults.
  - The NOP opcode constant 8'h00.
  - The fetch state encoding (IDLE=0, REQ=1).
- The control unit imports the same OPC_W.
- One natural sub-module: pc_counter, holding the PC register, increment/wrap, branch load and pending-branch register.
- FSM and IR stay in ifetch_ir.

Test Plan:
- Reset then fetch_req=1 for 1 cycle, memory ack on the 1st REQ cycle with rdata=16'hA13C -> mem_addr=0x00; opcode=0xA1, operand=0x3C, ir_valid=1 two edges after request; pc=0x01.
- Memory with 3 wait states, rdata=16'h0507 -> mem_rd high for 4 cycles with stable mem_addr, fetch_req pulses during REQ ignored; single capture, pc+1.
- IDLE with fetch_req=1 and branch_en=1, branch_addr=0x40 in the same cycle -> mem_addr=0x40 during REQ; after ack pc=0x41.
- branch_en with branch_addr=0x80 during REQ, then ack -> pc=0x80, not pc+1.
- pc=0xFF, fetch completes -> pc wraps to 0x00.
- Reset asserted in the 2nd wait cycle of REQ -> mem_rd=0 and ir_valid=0 immediately, pc=RESET_PC. With FETCH_TIMEOUT_EN and no ack -> abort after 15 REQ cycles, opcode=0x00, fetch_err=1, pc unchanged.
